// File: rtl/complex_power_arbiter_pkg.sv
// Shared helpers and tag type for complex_power_arbiter.
// COMPLEX_POWER_ARBITER_LAST_EN adds a last flag to the tag.
package complex_power_arbiter_pkg;

    // Widest channel tag needed for the supported range N_REQ <= 16.
    localparam int CH_MAX_WIDTH = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int ch_width(input int n_req);
        int r;
        r = clog2(n_req);
        return (r < 1) ? 1 : r;
    endfunction

    // (base + step) modulo n_req, for 0 <= base < n_req and 0 < step <= n_req.
    function automatic int wrap_idx(input int base, input int step, input int n_req);
        int s;
        s = base + step;
        if (s >= n_req) s -= n_req;
        return s;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [CH_MAX_WIDTH-1:0] ch;
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
        logic                    last;
`endif
    } tag_t;

endpackage

// File: rtl/complex_power.sv
// Fixed-latency |x|^2 = re^2 + im^2 datapath, full-width unsigned result.
// Only the valid pipeline is reset; LATENCY must be at least 2.
module complex_power #(
    parameter int DIN_WIDTH = 16,
    parameter int LATENCY   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DIN_WIDTH-1:0] din_re,
    input  logic signed [DIN_WIDTH-1:0] din_im,
    input  logic                        din_valid,
    output logic [2*DIN_WIDTH:0]        dout,
    output logic                        dout_valid
);

    localparam int PW = 2 * DIN_WIDTH;

    logic signed [PW-1:0] re_ext;
    logic signed [PW-1:0] im_ext;
    logic        [PW-1:0] re_sq;
    logic        [PW-1:0] im_sq;
    logic        [PW:0]   pow_pipe [LATENCY-1];
    logic [LATENCY-1:0]   vld;

    assign re_ext = PW'(din_re);
    assign im_ext = PW'(din_im);

    always_ff @(posedge clk) begin
        // NOTE: data registers carry no reset; the valid pipeline alone says
        // whether their contents mean anything.
        re_sq       <= re_ext * re_ext;
        im_sq       <= im_ext * im_ext;
        pow_pipe[0] <= {1'b0, re_sq} + {1'b0, im_sq};
        for (int i = 1; i < LATENCY - 1; i++) begin
            pow_pipe[i] <= pow_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld <= '0;
        else     vld <= {vld[LATENCY-2:0], din_valid};
    end

    assign dout       = pow_pipe[LATENCY-2];
    assign dout_valid = vld[LATENCY-1];

endmodule

// File: rtl/power_rr_grant.sv
// Round-robin grant over an eligibility mask, with the last-granted pointer.
// The channel after last_ptr has top priority; last_ptr moves only on a grant.
module power_rr_grant
    import complex_power_arbiter_pkg::*;
#(
    parameter  int N_REQ    = 4,
    localparam int CH_WIDTH = ch_width(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    eligible,
    output logic [N_REQ-1:0]    grant,
    output logic [CH_WIDTH-1:0] grant_idx,
    output logic                grant_valid
);

    logic [CH_WIDTH-1:0] last_ptr;
    logic [CH_WIDTH-1:0] cand;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the loop can leave a latch behind.
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        // Farthest candidate first, so the nearest eligible one overrides.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = CH_WIDTH'(wrap_idx(int'(last_ptr), k, N_REQ));
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = grant_valid ? (N_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before the edge.
        if (!rst_n) begin
            last_ptr <= CH_WIDTH'(N_REQ - 1);
        end else if (grant_valid) begin
            last_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/complex_power_arbiter.sv
// Round-robin sharing of one complex_power datapath between N_REQ channels.
// Optional macro COMPLEX_POWER_ARBITER_LAST_EN adds din_last / dout_last.
module complex_power_arbiter
    import complex_power_arbiter_pkg::*;
#(
    parameter  int DIN_WIDTH   = 16,
    parameter  int N_REQ       = 4,
    parameter  int POW_LATENCY = 4,
    localparam int CH_WIDTH    = ch_width(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           ch_en,
    input  logic [N_REQ*DIN_WIDTH-1:0] din_re,
    input  logic [N_REQ*DIN_WIDTH-1:0] din_im,
    input  logic [N_REQ-1:0]           din_valid,
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
    input  logic [N_REQ-1:0]           din_last,
`endif
    output logic [N_REQ-1:0]           din_ready,
    output logic [2*DIN_WIDTH:0]       dout,
    output logic [CH_WIDTH-1:0]        dout_ch,
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
    output logic                       dout_last,
`endif
    output logic                       dout_valid
);

    logic [N_REQ-1:0]           eligible;
    logic [N_REQ-1:0]           grant;
    logic [CH_WIDTH-1:0]        grant_idx;
    logic                       grant_valid;
    logic signed [DIN_WIDTH-1:0] mux_re;
    logic signed [DIN_WIDTH-1:0] mux_im;
    logic [2*DIN_WIDTH:0]       pow_dout;
    logic                       pow_valid;
    tag_t                       tag_in;
    tag_t                       tag_pipe [POW_LATENCY];
    tag_t                       tag_out;

    assign eligible = din_valid & ch_en;

    power_rr_grant #(
        .N_REQ(N_REQ)
    ) u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .eligible   (eligible),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // A grant is only ever given to a valid channel, so ready doubles as the transfer strobe.
    assign din_ready = grant;

    always_comb begin
        mux_re = '0;
        mux_im = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                mux_re = din_re[i*DIN_WIDTH +: DIN_WIDTH];
                mux_im = din_im[i*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    complex_power #(
        .DIN_WIDTH(DIN_WIDTH),
        .LATENCY  (POW_LATENCY)
    ) u_power (
        .clk       (clk),
        .rst       (1'b0),
        .din_re    (mux_re),
        .din_im    (mux_im),
        .din_valid (grant_valid),
        .dout      (pow_dout),
        .dout_valid(pow_valid)
    );

    always_comb begin
        tag_in = '0;
        if (grant_valid) begin
            tag_in.valid = 1'b1;
            tag_in.ch    = CH_MAX_WIDTH'(grant_idx);
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
            tag_in.last  = |(din_last & grant);
`endif
        end
    end

    // Tags are the source of truth for validity: clearing them on reset
    // suppresses any result still travelling through the unreset datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < POW_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < POW_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out    = tag_pipe[POW_LATENCY-1];
    assign dout_valid = tag_out.valid;
    assign dout_ch    = tag_out.ch[CH_WIDTH-1:0];
    assign dout       = pow_dout & {(2*DIN_WIDTH+1){tag_out.valid & pow_valid}};
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
    assign dout_last  = tag_out.valid & tag_out.last;
`endif

    ch_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(tag_out.ch) < N_REQ);

endmodule

// File: tb/tb_complex_power_arbiter.sv
// Bench for complex_power_arbiter: directed cases plus random traffic against
// a queue-based model of round-robin grant and fixed-latency power results.
`timescale 1ns/1ps
module tb_complex_power_arbiter;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LAT = 4;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     ch_en;
    logic [N*W-1:0]   din_re;
    logic [N*W-1:0]   din_im;
    logic [N-1:0]     din_valid;
    logic [N-1:0]     din_ready;
    logic [2*W:0]     dout;
    logic [CW-1:0]    dout_ch;
    logic             dout_valid;
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
    logic [N-1:0]     din_last;
    logic             dout_last;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    complex_power_arbiter #(
        .DIN_WIDTH  (W),
        .N_REQ      (N),
        .POW_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .din_re    (din_re),
        .din_im    (din_im),
        .din_valid (din_valid),
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
        .din_last  (din_last),
`endif
        .din_ready (din_ready),
        .dout      (dout),
        .dout_ch   (dout_ch),
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
        .dout_last (dout_last),
`endif
        .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: expected results keyed by the cycle they must appear.
    bit     exp_v  [int];
    int     exp_ch [int];
    longint exp_p  [int];
    bit     exp_l  [int];
    int     mptr;
    int     res_cnt [N] = '{default: 0};
    int     last_cnt = 0;
    int     last_ch  = -1;

    always @(negedge clk) begin : model
        logic [N-1:0] e;
        int     g;
        longint re;
        longint im;
        if (!rst_n) begin
            mptr = N - 1;
            exp_v.delete(); exp_ch.delete(); exp_p.delete(); exp_l.delete();
            check("reset dout_valid", dout_valid, 0);
            check("reset dout", dout, 0);
            check("reset dout_ch", dout_ch, 0);
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
            check("reset dout_last", dout_last, 0);
`endif
        end else begin
            if (exp_v.exists(cyc)) begin
                check("dout_valid", dout_valid, 1);
                check("dout_ch", dout_ch, exp_ch[cyc]);
                check("dout", dout, exp_p[cyc]);
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
                check("dout_last", dout_last, exp_l[cyc]);
`endif
                exp_v.delete(cyc); exp_ch.delete(cyc); exp_p.delete(cyc); exp_l.delete(cyc);
            end else begin
                check("idle dout_valid", dout_valid, 0);
                check("idle dout", dout, 0);
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
                check("idle dout_last", dout_last, 0);
`endif
            end
            if (dout_valid === 1'b1) res_cnt[dout_ch]++;
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
            if (dout_last === 1'b1) begin
                last_cnt++;
                last_ch = int'(dout_ch);
            end
`endif
            // Grant: first eligible index scanning upward from the last grant.
            e = din_valid & ch_en;
            g = -1;
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && e[(mptr + k) % N]) g = (mptr + k) % N;
            end
            check("din_ready", din_ready, (g < 0) ? 64'd0 : (64'd1 << g));
            if (g >= 0) begin
                re = longint'($signed(din_re[g*W +: W]));
                im = longint'($signed(din_im[g*W +: W]));
                exp_v[cyc + LAT]  = 1'b1;
                exp_ch[cyc + LAT] = g;
                exp_p[cyc + LAT]  = re * re + im * im;
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
                exp_l[cyc + LAT]  = din_last[g];
`else
                exp_l[cyc + LAT]  = 1'b0;
`endif
                mptr = g;
            end
        end
    end

    function automatic logic [W-1:0] rand_sample();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            din_re[i*W +: W] = rand_sample();
            din_im[i*W +: W] = rand_sample();
        end
        din_valid = v;
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
        din_last = N'($urandom);
`endif
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        din_valid = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        din_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base [N];
        ch_en = '1; din_valid = '0; din_re = '0; din_im = '0;
`ifdef COMPLEX_POWER_ARBITER_LAST_EN
        din_last = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("init dout_valid", dout_valid, 0);
        check("init dout", dout, 0);

        // Single sample on channel 2: 3^2 + (-4)^2 = 25 after exactly LAT cycles.
        @(posedge clk); #1;
        din_valid = 4'b0100;
        din_re[2*W +: W] = 16'd3;
        din_im[2*W +: W] = 16'hfffc;
        @(negedge clk);
        check("ch2 ready", din_ready, 4'b0100);
        idle_cycle();
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k < LAT) begin
                check("ch2 early valid", dout_valid, 0);
            end else begin
                check("ch2 valid", dout_valid, 1);
                check("ch2 dout", dout, 25);
                check("ch2 dout_ch", dout_ch, 2);
            end
        end

        // All channels valid: grants 0,1,2,3,... and 4 results per channel.
        do_reset();
        for (int i = 0; i < N; i++) base[i] = res_cnt[i];
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            drive('1);
            @(negedge clk);
            check("rr order", din_ready, 64'd1 << (k % N));
        end
        idle_cycle();
        repeat (LAT + 1) @(negedge clk);
        for (int i = 0; i < N; i++) check("rr count", res_cnt[i] - base[i], 4);

        // Largest-magnitude input on channel 1: 2^31 without wrap.
        @(posedge clk); #1;
        din_valid = 4'b0010;
        din_re[1*W +: W] = 16'h8000;
        din_im[1*W +: W] = 16'h8000;
        idle_cycle();
        repeat (LAT - 1) @(negedge clk);
        @(negedge clk);
        check("max dout", dout, 64'd2147483648);
        check("max bit32", dout[32], 0);
        check("max dout_ch", dout_ch, 1);

        // Only channels 1 and 3 enabled.
        ch_en = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            drive('1);
            @(negedge clk);
            check("masked ready", din_ready & 4'b0101, 0);
            check("masked granted", |din_ready, 1);
        end
        ch_en = '1;
        idle_cycle();
        repeat (LAT + 1) @(negedge clk);

        // Reset with three results in flight: nothing stale after release.
        repeat (3) begin
            @(posedge clk); #1;
            drive('1);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        din_valid = '0;
        @(negedge clk);
        check("flight reset valid", dout_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post-reset quiet", dout_valid, 0);
        end
        @(posedge clk); #1;
        drive('1);
        @(negedge clk);
        check("post-reset grant", din_ready, 4'b0001);
        idle_cycle();
        repeat (LAT + 1) @(negedge clk);

`ifdef COMPLEX_POWER_ARBITER_LAST_EN
        // Eight samples on channel 3, last flag on the eighth only.
        base[0] = last_cnt;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            drive(4'b1000);
            din_last = (k == 7) ? 4'b1000 : 4'b0000;
        end
        idle_cycle();
        repeat (LAT + 1) @(negedge clk);
        check("last count", last_cnt - base[0], 1);
        check("last channel", last_ch, 3);
`endif

        // Random traffic with occasional enable-mask changes.
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (k % 50 == 0) ch_en = N'($urandom);
            drive(N'($urandom));
        end
        ch_en = '1;
        idle_cycle();
        repeat (LAT + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/complex_power_arbiter.md
# complex_power_arbiter

Shares one `complex_power` datapath (|x|² = re² + im²) between N_REQ sample streams, such as per-antenna or per-bin channels of the DOA front end. Each cycle, a round-robin arbiter picks at most one requesting channel and issues its sample into the datapath. The channel tag travels through a fixed-latency tag pipeline in step with the datapath, so each power result leaves labelled with its source channel. The block sits between the channel buffers and the per-channel power/covariance accumulators.

## Interface
- `DIN_WIDTH`, 16, signed width of each re/im component.
- `N_REQ`, 4, number of requesting channels (2..16).
- `POW_LATENCY`, 4, cycles from datapath input to `complex_power` `dout_valid`. Must equal the instantiated datapath latency.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ch_en` in N_REQ: per-channel enable mask (configuration); bit i=0 means channel i is never granted.
- `din_re` in N_REQ*DIN_WIDTH: packed signed real parts, channel i at bits [i*DIN_WIDTH +: DIN_WIDTH].
- `din_im` in N_REQ*DIN_WIDTH: packed signed imaginary parts, same packing.
- `din_valid` in N_REQ: per-channel valid.
- `din_ready` out N_REQ: per-channel ready; one-hot or zero.
- `dout` out 2*DIN_WIDTH+1: unsigned power of the granted sample.
- `dout_ch` out CH_WIDTH: source channel of `dout`; CH_WIDTH = max(1, clog2(N_REQ)).
- `dout_valid` out 1: result strobe.

## Operation
- Eligible set: E = `din_valid` & `ch_en`.
- Grant: the first index in E, scanning upward from `last_ptr`+1 with wrap modulo N_REQ.
  - `din_ready` = one-hot(grant), combinational from E and `last_ptr`.
  - `din_ready` = 0 when E = 0.
- Transfer: channel i transfers when `din_valid[i]` & `din_ready[i]`. At most one transfer per cycle.
- On a transfer:
  - The muxed re/im goes to the datapath with its valid = 1.
  - `last_ptr` <= granted index.
  - The tag {valid=1, ch} enters tag stage 0.
- With no transfer: datapath valid = 0, a bubble tag enters, and `last_ptr` holds.
- Tag pipeline: POW_LATENCY registers, so a result and its tag emerge on the same cycle.
- Outputs:
  - `dout_valid` = last tag valid.
  - `dout_ch` = last tag ch.
  - `dout` = datapath result ANDed with `dout_valid`, so it is 0 whenever invalid.
- No output backpressure. Downstream must accept one result per cycle.
- Arithmetic: re² + im² computed at full width. Max (-2^(DIN_WIDTH-1))²·2 = 2^(2·DIN_WIDTH-1), with no overflow.
- `ch_en` changes take effect on the next arbitration cycle. Results already in flight still emerge.

## Timing
- Reset values:
  - `last_ptr` = N_REQ-1, so channel 0 wins the first contention.
  - All tags invalid.
  - `dout_valid` = 0, `dout_ch` = 0, `dout` = 0.
  - `din_ready` follows E combinationally. It must not be used before `rst_n` release.
- Latency: transfer at cycle t → `dout_valid` at t+POW_LATENCY.
- Throughput: 1 sample/cycle aggregate.
- Fairness: with all N_REQ channels continuously valid, each channel is granted exactly once every N_REQ cycles.
- Reset asserted mid-flight: all tags clear immediately and no stale result is emitted after release. Datapath internals need no reset because the output is masked.

## Configuration
- `COMPLEX_POWER_ARBITER_LAST_EN` defined: adds ports `din_last` in N_REQ and `dout_last` out 1.
  - `din_last` is carried in the tag alongside ch.
  - `dout_last` is asserted with the matching result, and is 0 whenever `dout_valid` = 0.
  - Reset value of `dout_last` is 0.
- Not defined: neither port exists, and the tag holds only {valid, ch}.

## Structure
- Package `complex_power_arbiter_pkg`:
  - CH_WIDTH computation (clog2 helper).
  - Tag typedef {valid, ch, last (under macro)}.
- Sub-module `power_rr_grant`: round-robin grant logic plus `last_ptr` register, parameterised by N_REQ.
- The datapath is the existing `complex_power` instance, with its rst tied to 0.
- The top level holds only the data mux, the tag pipeline and the output masking.

## Test plan
- Channel 2 only, re=3, im=-4 → `dout`=25, `dout_ch`=2, `dout_valid` exactly POW_LATENCY cycles after the transfer.
- All 4 channels valid continuously for 16 cycles → grants cycle 0,1,2,3,0,… Each channel gets 4 results and `dout_ch` follows the same order.
- re=im=-32768 on channel 1 → `dout`=2147483648 (bit 31 set, bit 32 clear), with no wrap.
- `ch_en`=4'b1010 with all valid → only channels 1 and 3 alternate, and `din_ready[0]`/`din_ready[2]` stay 0.
- Reset pulse while 3 results are in flight → no `dout_valid` after release until new transfers, and first grant goes to channel 0.
- With `COMPLEX_POWER_ARBITER_LAST_EN`: `din_last` on the 8th sample of channel 3 → `dout_last`=1 only on that result, with `dout_ch`=3.
